// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state FSM encoding, FIFO sizing and the
// 8N1 frame constants used by both the receive and transmit halves.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_START_BIT = 2'd1,
    RX_DATA_BITS = 2'd2,
    RX_STOP_BIT  = 2'd3
  } uart_state_t;

  localparam int FIFO_BITS  = 4;
  localparam int FIFO_DEPTH = 1 << FIFO_BITS;

  // 8N1 framing: one low start bit, eight data bits LSB first, one high stop bit.
  localparam int         FRAME_DATA_BITS = 8;
  localparam logic       START_LEVEL     = 1'b0;
  localparam logic       STOP_LEVEL      = 1'b1;
  localparam logic       LINE_IDLE       = 1'b1;
  localparam logic [2:0] LAST_DATA_BIT   = 3'(FRAME_DATA_BITS - 1);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input. Both flops
// reset to RESET_VAL so the output does not glitch when reset releases.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so both flops sample
    // their inputs simultaneously; blocking here would collapse the chain.
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16-entry (15 usable) RX FIFO drained through a
// single-beat stb/cyc/ack read port. Define UART_RX_ERR_EN to add the
// err_o port carrying sticky {overflow, framing} flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 62
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stb_i,
  input  logic       cyc_i,
  output logic [7:0] data_o,
  output logic       ack_o,
  output logic       rx_ready_o,
`ifdef UART_RX_ERR_EN
  output logic [1:0] err_o,
`endif
  input  logic       uart_rxd_i
);

  localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT);
  localparam logic [15:0] BIT_MID = 16'(CLKS_PER_BIT / 2);

  logic                       rxd_s;
  uart_state_t                state, state_next;
  logic [15:0]                clock_count, count_next;
  logic [2:0]                 bit_index, bit_next;
  logic [FRAME_DATA_BITS-1:0] rx_byte, byte_next;
  logic                       stop_done;

  logic [7:0]                 mem [FIFO_DEPTH];
  logic [FIFO_BITS-1:0]       wr_ptr, rd_ptr, wr_ptr_inc;
  logic                       full, empty, push, pop, sync_ack;

  sync_2ff #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (uart_rxd_i),
    .q   (rxd_s)
  );

  // Next-state and bit-timing logic for the receive FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_next = state;
    count_next = clock_count + 16'd1;
    bit_next   = bit_index;
    byte_next  = rx_byte;
    stop_done  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rxd_s == START_LEVEL) begin
          count_next = 16'd1;
          state_next = RX_START_BIT;
        end
      end
      RX_START_BIT: begin
        if (clock_count == BIT_MID) begin
          if (rxd_s != START_LEVEL) begin
            state_next = RX_IDLE;  // line went back high: a glitch, not a start
          end else begin
            count_next = 16'd1;
            bit_next   = 3'd0;
            state_next = RX_DATA_BITS;
          end
        end
      end
      RX_DATA_BITS: begin
        if (clock_count == BIT_END) begin
          byte_next[bit_index] = rxd_s;
          count_next           = 16'd1;
          if (bit_index == LAST_DATA_BIT) state_next = RX_STOP_BIT;
          else                            bit_next   = bit_index + 3'd1;
        end
      end
      RX_STOP_BIT: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (clock_count == BIT_END) begin
          stop_done  = 1'b1;
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RX_IDLE;
      clock_count <= '0;
      bit_index   <= '0;
      rx_byte     <= '0;
    end else begin
      state       <= state_next;
      clock_count <= count_next;
      bit_index   <= bit_next;
      rx_byte     <= byte_next;
    end
  end

  assign wr_ptr_inc = wr_ptr + 1'b1;
  assign full       = (rd_ptr == wr_ptr_inc);
  assign empty      = (rd_ptr == wr_ptr);
  assign push       = stop_done && (rxd_s == STOP_LEVEL) && !full;
  assign pop        = stb_i && cyc_i && !sync_ack && !empty;
  assign ack_o      = sync_ack & stb_i;
  assign rx_ready_o = !empty;

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are valid, so clearing it would only cost flops.
    if (push) mem[wr_ptr] <= rx_byte;
  end

  // FIFO pointers and the single-beat read handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_o   <= '0;
      sync_ack <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr_inc;
      if (pop) begin
        data_o   <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        sync_ack <= 1'b1;
      end else if (sync_ack) begin
        sync_ack <= stb_i;  // hold off further pops until the strobe drops
      end
    end
  end

`ifdef UART_RX_ERR_EN
  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 2'b00;
    end else begin
      if (pop) err_o <= 2'b00;
      if (stop_done && (rxd_s == STOP_LEVEL) && full) err_o[1] <= 1'b1;
      if (stop_done && (rxd_s != STOP_LEVEL))         err_o[0] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8. Expected bytes go into a
// scoreboard queue as frames are sent and are compared as reads complete.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       cyc = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       ack;
  logic       ready;
`ifdef UART_RX_ERR_EN
  logic [1:0] err;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb [$];
  logic [7:0] pat;
  int         n;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stb_i      (stb),
    .cyc_i      (cyc),
    .data_o     (data),
    .ack_o      (ack),
    .rx_ready_o (ready),
`ifdef UART_RX_ERR_EN
    .err_o      (err),
`endif
    .uart_rxd_i (rxd)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and land just after the rising edge.
  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    step(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  // One read transaction; the expected byte comes from the scoreboard.
  task automatic do_read();
    logic [7:0] exp;
    exp = sb.pop_front();
    stb = 1'b1;
    cyc = 1'b1;
    @(negedge clk);
    check("rd_noack_early", 16'(ack), 16'd0);
    step(1);
    @(negedge clk);
    check("rd_ack", 16'(ack), 16'd1);
    check("rd_data", 16'(data), 16'(exp));
    step(1);
    stb = 1'b0;
    cyc = 1'b0;
    #1;
    check("rd_ack_drop", 16'(ack), 16'd0);
    step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 16'(ack), 16'd0);
    check("rst_data", 16'(data), 16'd0);
    check("rst_ready", 16'(ready), 16'd0);
`ifdef UART_RX_ERR_EN
    check("rst_err", 16'(err), 16'd0);
`endif
    step(1);

    // Single byte.
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    check("single_ready", 16'(ready), 16'd1);
    step(1);
    do_read();
    @(negedge clk);
    check("single_empty", 16'(ready), 16'd0);
    step(1);

    // Glitch: three low cycles on an idle line.
    rxd = 1'b0;
    step(3);
    rxd = 1'b1;
    step(24);
    @(negedge clk);
    check("glitch_ready", 16'(ready), 16'd0);
    step(1);

    // Framing error: stop bit low.
    send_frame(8'h3C, 1'b0);
    rxd = 1'b1;
    step(24);
    @(negedge clk);
    check("frame_ready", 16'(ready), 16'd0);
`ifdef UART_RX_ERR_EN
    check("frame_err", 16'(err), 16'd1);
`endif
    step(1);
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    @(negedge clk);
    check("after_frame_ready", 16'(ready), 16'd1);
`ifdef UART_RX_ERR_EN
    check("frame_err_sticky", 16'(err), 16'd1);
`endif
    step(1);
    do_read();
`ifdef UART_RX_ERR_EN
    @(negedge clk);
    check("frame_err_clear", 16'(err), 16'd0);
    step(1);
`endif

    // Overflow and pointer wrap: 16 frames into a 15-deep FIFO.
    for (int i = 0; i < 16; i++) begin
      if (sb.size() < 15) sb.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    @(negedge clk);
    check("ovf_ready", 16'(ready), 16'd1);
`ifdef UART_RX_ERR_EN
    check("ovf_err", 16'(err), 16'd2);
`endif
    step(1);
    check("ovf_sb_depth", 16'(sb.size()), 16'd15);
    for (int i = 0; i < 15; i++) begin
      do_read();
`ifdef UART_RX_ERR_EN
      if (i == 0) begin
        @(negedge clk);
        check("ovf_err_clear", 16'(err), 16'd0);
        step(1);
      end
`endif
    end
    @(negedge clk);
    check("ovf_drained", 16'(ready), 16'd0);
    step(1);

    // Read stall on an empty FIFO.
    stb = 1'b1;
    cyc = 1'b1;
    step(20);
    @(negedge clk);
    check("stall_noack", 16'(ack), 16'd0);
    step(1);
    sb.push_back(8'h5A);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        n = 0;
        while (!ready && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("stall_ready", 16'(ready), 16'd1);
        check("stall_ack_late", 16'(ack), 16'd0);
        @(negedge clk);
        check("stall_ack", 16'(ack), 16'd1);
        check("stall_data", 16'(data), 16'(sb.pop_front()));
        check("stall_popped", 16'(ready), 16'd0);
      end
    join
    step(1);
    // Holding the strobe must not pop the next byte.
    sb.push_back(8'h66);
    send_frame(8'h66, 1'b1);
    @(negedge clk);
    check("hold_ack", 16'(ack), 16'd1);
    check("hold_data", 16'(data), 16'h5A);
    check("hold_nopop", 16'(ready), 16'd1);
    step(1);
    stb = 1'b0;
    cyc = 1'b0;
    #1;
    check("hold_ack_drop", 16'(ack), 16'd0);
    step(2);
    do_read();

    // Reset during bit 4 of a frame, with a byte already buffered.
    send_frame(8'h77, 1'b1);
    @(negedge clk);
    check("pre_rst_ready", 16'(ready), 16'd1);
    step(1);
    pat = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(pat[i]);
    rxd = pat[4];
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", 16'(ack), 16'd0);
    check("mid_rst_data", 16'(data), 16'd0);
    check("mid_rst_ready", 16'(ready), 16'd0);
`ifdef UART_RX_ERR_EN
    check("mid_rst_err", 16'(err), 16'd0);
`endif
    step(20);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    @(negedge clk);
    check("post_rst_ready", 16'(ready), 16'd1);
    step(1);
    do_read();
    @(negedge clk);
    check("post_rst_empty", 16'(ready), 16'd0);
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
